board_link_ctrl: RTL and testbench



---
 rtl/board_link_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_board_link_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_link_ctrl.sv
// Purpose : two-board cable link controller (heartbeat handshake, link FSM, role, gated P2 buttons).
// Latency : inputs pass 2 sync flops; peer edge -> FSM 3 edges, buttons -> p2_btn 3 edges, role 3 (DOWN) / 4 (UP) edges.
// Backpr. : none; free-running, every output is a plain register updated each cycle.
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   sw_master          async role switch (1 = master)
//   hb_in / hb_out     peer heartbeat in (async) / local heartbeat out
//   p2_btn_raw         async cable buttons {attack, right, left, down, up}
//   p2_btn             synchronized buttons, forced to 0 unless link up and master
//   is_master          registered role, drives the cable pin mux select
//   link_up            high while the link FSM is in UP
//   link_lost_pulse    one-cycle pulse on every exit from UP (never from reset)
module board_link_ctrl #(
  parameter int HB_PERIOD = 1000,
  parameter int TIMEOUT   = 4096,
  parameter int ACQ_EDGES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw_master,
  input  logic       hb_in,
  output logic       hb_out,
  input  logic [4:0] p2_btn_raw,
  output logic [4:0] p2_btn,
  output logic       is_master,
  output logic       link_up,
  output logic       link_lost_pulse
);

  localparam int HBW  = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;
  localparam int SILW = $clog2(TIMEOUT + 1);

  localparam logic [HBW-1:0]  HB_LAST = HBW'(HB_PERIOD - 1);
  localparam logic [SILW-1:0] SIL_MAX = SILW'(TIMEOUT);
  localparam logic [3:0]      ACQ_TGT = 4'(ACQ_EDGES);

  localparam logic [1:0] ST_DOWN = 2'd0;
  localparam logic [1:0] ST_ACQ  = 2'd1;
  localparam logic [1:0] ST_UP   = 2'd2;

  // synchronizers
  logic       sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic       hb_s1_q, hb_s1_d, hb_s2_q, hb_s2_d, hb_prev_q, hb_prev_d;
  logic [4:0] btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;

  // heartbeat transmit and silence tracking
  logic [HBW-1:0]  hb_cnt_q, hb_cnt_d;
  logic            hb_out_q, hb_out_d;
  logic [SILW-1:0] sil_cnt_q, sil_cnt_d;

  // link FSM and registered outputs
  logic [1:0] state_q, state_d;
  logic [3:0] acq_cnt_q, acq_cnt_d;
  logic       is_master_q, is_master_d;
  logic       link_up_q, link_up_d;
  logic       link_lost_q, link_lost_d;
  logic [4:0] p2_btn_q, p2_btn_d;

  logic peer_edge;
  logic timeout;
  logic role_flip;
  logic hb_wrap;

  always_comb begin
    sw_s1_d   = sw_master;
    sw_s2_d   = sw_s1_q;
    hb_s1_d   = hb_in;
    hb_s2_d   = hb_s1_q;
    hb_prev_d = hb_s2_q;
    btn_s1_d  = p2_btn_raw;
    btn_s2_d  = btn_s1_q;

    // either heartbeat polarity counts as a peer edge
    peer_edge = hb_s2_q ^ hb_prev_q;

    hb_wrap  = (hb_cnt_q == HB_LAST);
    hb_cnt_d = hb_wrap ? '0 : hb_cnt_q + HBW'(1);
    hb_out_d = hb_out_q ^ hb_wrap;

    if (peer_edge) begin
      sil_cnt_d = '0;
    end else if (sil_cnt_q != SIL_MAX) begin
      sil_cnt_d = sil_cnt_q + SILW'(1);
    end else begin
      sil_cnt_d = sil_cnt_q;
    end
    timeout   = (sil_cnt_q == SIL_MAX);
    role_flip = (sw_s2_q != is_master_q);

    state_d     = state_q;
    acq_cnt_d   = acq_cnt_q;
    is_master_d = is_master_q;

    case (state_q)
      ST_DOWN: begin
        // role is only allowed to change while the link is down
        is_master_d = sw_s2_q;
        acq_cnt_d   = 4'd0;
        if (peer_edge) begin
          acq_cnt_d = 4'd1;
          state_d   = (ACQ_TGT == 4'd1) ? ST_UP : ST_ACQ;
        end
      end
      ST_ACQ: begin
        // role flip beats peer edge, peer edge beats timeout
        if (role_flip) begin
          state_d   = ST_DOWN;
          acq_cnt_d = 4'd0;
        end else if (peer_edge) begin
          acq_cnt_d = acq_cnt_q + 4'd1;
          if ((acq_cnt_q + 4'd1) == ACQ_TGT) begin
            state_d = ST_UP;
          end
        end else if (timeout) begin
          state_d   = ST_DOWN;
          acq_cnt_d = 4'd0;
        end
      end
      ST_UP: begin
        if (role_flip || (timeout && !peer_edge)) begin
          state_d   = ST_DOWN;
          acq_cnt_d = 4'd0;
        end
      end
      default: begin
        state_d   = ST_DOWN;
        acq_cnt_d = 4'd0;
      end
    endcase

    // link_up is registered from the next state so it tracks UP exactly
    link_up_d   = (state_d == ST_UP);
    link_lost_d = (state_q == ST_UP) && (state_d == ST_DOWN);
    p2_btn_d    = btn_s2_q & {5{link_up_q & is_master_q}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1_q     <= 1'b0;
      sw_s2_q     <= 1'b0;
      hb_s1_q     <= 1'b0;
      hb_s2_q     <= 1'b0;
      hb_prev_q   <= 1'b0;
      btn_s1_q    <= 5'd0;
      btn_s2_q    <= 5'd0;
      hb_cnt_q    <= '0;
      hb_out_q    <= 1'b0;
      sil_cnt_q   <= '0;
      state_q     <= ST_DOWN;
      acq_cnt_q   <= 4'd0;
      is_master_q <= 1'b0;
      link_up_q   <= 1'b0;
      link_lost_q <= 1'b0;
      p2_btn_q    <= 5'd0;
    end else begin
      sw_s1_q     <= sw_s1_d;
      sw_s2_q     <= sw_s2_d;
      hb_s1_q     <= hb_s1_d;
      hb_s2_q     <= hb_s2_d;
      hb_prev_q   <= hb_prev_d;
      btn_s1_q    <= btn_s1_d;
      btn_s2_q    <= btn_s2_d;
      hb_cnt_q    <= hb_cnt_d;
      hb_out_q    <= hb_out_d;
      sil_cnt_q   <= sil_cnt_d;
      state_q     <= state_d;
      acq_cnt_q   <= acq_cnt_d;
      is_master_q <= is_master_d;
      link_up_q   <= link_up_d;
      link_lost_q <= link_lost_d;
      p2_btn_q    <= p2_btn_d;
    end
  end

  assign hb_out          = hb_out_q;
  assign is_master       = is_master_q;
  assign link_up         = link_up_q;
  assign link_lost_pulse = link_lost_q;
  assign p2_btn          = p2_btn_q;

endmodule

// File: tb/tb_board_link_ctrl.sv
// Purpose : self-checking bench for board_link_ctrl (scoreboard against a time-based reference model).
// Latency : expectations are tagged with the clock edge they belong to and checked after that edge.
// Backpr. : none; the DUT presents a full output vector on every cycle.
module tb_board_link_ctrl;

  localparam int HB   = 8;
  localparam int TO   = 32;
  localparam int ACQ  = 3;
  localparam int MAXE = 8192;

  logic       clk;
  logic       reset;
  logic       sw_master;
  logic       hb_in;
  logic       hb_out;
  logic [4:0] p2_btn_raw;
  logic [4:0] p2_btn;
  logic       is_master;
  logic       link_up;
  logic       link_lost_pulse;

  board_link_ctrl #(.HB_PERIOD(HB), .TIMEOUT(TO), .ACQ_EDGES(ACQ)) dut (
    .clk             (clk),
    .reset           (reset),
    .sw_master       (sw_master),
    .hb_in           (hb_in),
    .hb_out          (hb_out),
    .p2_btn_raw      (p2_btn_raw),
    .p2_btn          (p2_btn),
    .is_master       (is_master),
    .link_up         (link_up),
    .link_lost_pulse (link_lost_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int edge_cnt = 0;
  initial forever begin
    @(posedge clk);
    edge_cnt = edge_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         k;
    logic [8:0] v;   // {hb_out, is_master, link_up, link_lost_pulse, p2_btn}
  } exp_t;
  exp_t sb[$];

  // input history, indexed by the clock edge that samples it
  bit         h_rst [MAXE];
  bit         h_sw  [MAXE];
  bit         h_hb  [MAXE];
  logic [4:0] h_btn [MAXE];

  // reference model state
  int         m_seen;       // consecutive peer edges seen since link went down
  bit         m_master, m_up, m_lost, m_hbout;
  logic [4:0] m_btn;
  int         m_last_clr, m_last_rst, m_last_pe;

  function automatic bit rst_at(int k);
    return (k < 1) ? 1'b1 : h_rst[k];
  endfunction

  // value a 2-flop synchronizer holds just after edge k
  function automatic bit s2_sw(int k);
    if (rst_at(k) || rst_at(k - 1)) return 1'b0;
    return h_sw[k - 1];
  endfunction
  function automatic bit s2_hb(int k);
    if (rst_at(k) || rst_at(k - 1)) return 1'b0;
    return h_hb[k - 1];
  endfunction
  function automatic logic [4:0] s2_btn(int k);
    if (rst_at(k) || rst_at(k - 1)) return 5'd0;
    return h_btn[k - 1];
  endfunction
  function automatic bit prev_hb(int k);
    if (rst_at(k) || rst_at(k - 1) || rst_at(k - 2)) return 1'b0;
    return h_hb[k - 2];
  endfunction
  // a peer edge is acted on at edge k when the synchronized heartbeat changed
  function automatic bit pe_at(int k);
    if (rst_at(k)) return 1'b0;
    return s2_hb(k - 1) ^ prev_hb(k - 1);
  endfunction

  task automatic model_edge(input int k);
    bit to, p, sw2, was_up, up_prev, master_prev;
    if (rst_at(k)) begin
      m_seen = 0; m_master = 0; m_up = 0; m_lost = 0; m_btn = 5'd0;
      m_hbout = 0; m_last_rst = k; m_last_clr = k;
      return;
    end
    to          = (k - 1 - m_last_clr) >= TO;
    p           = pe_at(k);
    up_prev     = m_up;
    master_prev = m_master;
    m_btn       = (up_prev && master_prev) ? s2_btn(k - 1) : 5'd0;
    sw2         = s2_sw(k - 1);
    was_up      = (m_seen >= ACQ);
    m_lost      = 0;
    if (m_seen == 0) m_master = sw2;
    if (m_seen > 0 && sw2 != master_prev) begin
      m_seen = 0;
      m_lost = was_up;
    end else if (p) begin
      m_seen = (m_seen + 1 > ACQ) ? ACQ : m_seen + 1;
    end else if (m_seen > 0 && to) begin
      m_seen = 0;
      m_lost = was_up;
    end
    if (p) begin
      m_last_clr = k;
      m_last_pe  = k;
    end
    m_up    = (m_seen >= ACQ);
    m_hbout = (((k - m_last_rst) / HB) % 2) == 1;
  endtask

  // drive inputs for the next edge, predict its outputs, then move past that edge
  task automatic step(input bit r, input bit sw, input bit hb, input logic [4:0] b);
    int k;
    k          = edge_cnt + 1;
    reset      = r;
    sw_master  = sw;
    hb_in      = hb;
    p2_btn_raw = b;
    h_rst[k]   = r;
    h_sw[k]    = sw;
    h_hb[k]    = hb;
    h_btn[k]   = b;
    model_edge(k);
    sb.push_back('{k, {m_hbout, m_master, m_up, m_lost, m_btn}});
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, edge_cnt);
    end
  endtask

  // monitor: compares each edge's outputs against the queued expectation
  exp_t       mon_e;
  logic [8:0] mon_got;
  initial forever begin
    @(negedge clk);
    while (sb.size() > 0 && sb[0].k <= edge_cnt) begin
      mon_e   = sb.pop_front();
      mon_got = {hb_out, is_master, link_up, link_lost_pulse, p2_btn};
      checks  = checks + 1;
      if (mon_e.k != edge_cnt || mon_got !== mon_e.v) begin
        errors = errors + 1;
        $display("FAIL scoreboard edge %0d: got %b expected %b", mon_e.k, mon_got, mon_e.v);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog expired");
  end

  int         fall, pulses, j, upmax, downseen, btnor;
  bit         hold, hbv, swv, r;
  int         gap;
  logic [4:0] bv;

  initial begin
    reset = 1'b1; sw_master = 1'b0; hb_in = 1'b0; p2_btn_raw = 5'd0;

    // reset with random inputs
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), 1'($urandom), 5'($urandom));
    chk("reset_outputs", 32'({hb_out, is_master, link_up, link_lost_pulse, p2_btn}), 32'd0);

    // loopback as master
    for (int t = 1; t <= 40; t++) begin
      step(1'b0, 1'b1, m_hbout, 5'd0);
      if (t == 2)  chk("master_t2", 32'(is_master), 32'd0);
      if (t == 3)  chk("master_t3", 32'(is_master), 32'd1);
      if (t == 7)  chk("hb_out_t7", 32'(hb_out), 32'd0);
      if (t == 8)  chk("hb_out_t8", 32'(hb_out), 32'd1);
      if (t == 16) chk("hb_out_t16", 32'(hb_out), 32'd0);
      if (t == 26) chk("link_up_t26", 32'(link_up), 32'd0);
      if (t == 27) chk("link_up_t27", 32'(link_up), 32'd1);
    end

    // link loss: freeze heartbeat
    hold = m_hbout; fall = -1; pulses = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'b1, hold, 5'd0);
      if (link_lost_pulse) pulses = pulses + 1;
      if (fall < 0 && !link_up) fall = edge_cnt;
    end
    chk("loss_delay", 32'(fall - m_last_pe), 32'(TO + 1));
    chk("loss_pulse_count", 32'(pulses), 32'd1);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, m_hbout, 5'd0);
    chk("reacquire", 32'(link_up), 32'd1);

    // button gating
    step(1'b0, 1'b1, m_hbout, 5'b10101);
    step(1'b0, 1'b1, m_hbout, 5'b10101);
    chk("btn_lat2", 32'(p2_btn), 32'd0);
    step(1'b0, 1'b1, m_hbout, 5'b10101);
    chk("btn_lat3", 32'(p2_btn), 32'b10101);
    step(1'b0, 1'b0, m_hbout, 5'b10101);
    step(1'b0, 1'b0, m_hbout, 5'b10101);
    step(1'b0, 1'b0, m_hbout, 5'b10101);
    chk("flip_master_e3", 32'(is_master), 32'd1);
    chk("flip_link_down_e3", 32'(link_up), 32'd0);
    chk("flip_lost_pulse_e3", 32'(link_lost_pulse), 32'd1);
    step(1'b0, 1'b0, m_hbout, 5'b10101);
    chk("flip_master_e4", 32'(is_master), 32'd0);
    chk("flip_btn_e4", 32'(p2_btn), 32'd0);
    btnor = 0;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b0, m_hbout, 5'b11111);
      btnor = btnor | int'(p2_btn);
    end
    chk("slave_btn_zero", 32'(btnor), 32'd0);
    chk("slave_link_up", 32'(link_up), 32'd1);

    // role flip while acquiring
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 5'd0);
    for (int i = 0; i < 100 && m_seen != 2; i++) step(1'b0, 1'b1, m_hbout, 5'd0);
    chk("acq2_link_down", 32'(link_up), 32'd0);
    pulses = 0; upmax = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, m_hbout, 5'd0);
      if (link_lost_pulse) pulses = pulses + 1;
      if (link_up) upmax = 1;
    end
    chk("acqflip_no_pulse", 32'(pulses), 32'd0);
    chk("acqflip_no_up", 32'(upmax), 32'd0);
    chk("acqflip_master", 32'(is_master), 32'd0);

    // peer edge on the same cycle the timeout is reached
    for (int i = 0; i < 100 && !m_up; i++) step(1'b0, 1'b0, m_hbout, 5'd0);
    chk("corner_up", 32'(link_up), 32'd1);
    hold = m_hbout;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, hold, 5'd0);
    j = m_last_pe; pulses = 0; downseen = 0;
    for (int i = 0; i < 60 && edge_cnt < j + 45; i++) begin
      if (edge_cnt + 1 == j + TO - 1) hold = !hold;
      step(1'b0, 1'b0, hold, 5'd0);
      if (link_lost_pulse) pulses = pulses + 1;
      if (!link_up) downseen = 1;
    end
    chk("corner_stays_up", 32'(downseen), 32'd0);
    chk("corner_no_pulse", 32'(pulses), 32'd0);
    chk("corner_edge_cycle", 32'(m_last_pe - j), 32'(TO + 1));

    // randomized traffic
    gap = 3; hbv = 1'b0; swv = 1'b1; bv = 5'd0;
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(299, 0) == 0);
      if ($urandom_range(149, 0) == 0) swv = !swv;
      if ($urandom_range(3, 0) == 0) bv = 5'($urandom);
      gap = gap - 1;
      if (gap <= 0) begin
        hbv = !hbv;
        gap = ($urandom_range(9, 0) == 0) ? int'($urandom_range(40, 28)) : int'($urandom_range(12, 1));
      end
      step(r, swv, hbv, bv);
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
